// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer constants, entry type encoding and issue decode.
// The reserved type encoding is folded onto a register write to x0.
package reorder_buffer_pkg;

  localparam int ROB_WIDTH_BIT = 3;
  localparam int REG_ID_BIT    = 5;

  typedef enum logic [1:0] {
    ROB_TYPE_REG    = 2'd0,
    ROB_TYPE_STORE  = 2'd1,
    ROB_TYPE_BRANCH = 2'd2,
    ROB_TYPE_RSVD   = 2'd3
  } rob_type_e;

  typedef struct packed {
    rob_type_e             kind;
    logic [REG_ID_BIT-1:0] rd;
  } issue_dec_t;

  function automatic issue_dec_t decode_issue(input logic [1:0]            raw,
                                              input logic [REG_ID_BIT-1:0] rd);
    issue_dec_t dec;
    dec.kind = rob_type_e'(raw);
    dec.rd   = rd;
    if (raw == 2'd3) begin
      dec.kind = ROB_TYPE_REG;
      dec.rd   = '0;
    end
    return dec;
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch / CDB / commit bundle of the reorder buffer.
// master = dispatch and CDB side, slave = the reorder buffer itself.
interface reorder_buffer_if
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH_BIT = ROB_WIDTH_BIT
) ();

  logic                  issue_valid;
  logic                  issue_ready;
  logic [1:0]            issue_type;
  logic [REG_ID_BIT-1:0] issue_rd;
  logic                  issue_pred_taken;
  logic [31:0]           issue_alt_pc;
  logic [DEPTH_BIT-1:0]  issue_rob_id;

  logic                  cdb_valid;
  logic [DEPTH_BIT-1:0]  cdb_rob_id;
  logic [31:0]           cdb_value;
  logic                  cdb_taken;

  logic [DEPTH_BIT-1:0]  qa_id;
  logic [DEPTH_BIT-1:0]  qb_id;
  logic                  qa_ready;
  logic                  qb_ready;
  logic [31:0]           qa_value;
  logic [31:0]           qb_value;

  logic                  commit_valid;
  logic [REG_ID_BIT-1:0] commit_rd;
  logic [31:0]           commit_value;
  logic [DEPTH_BIT-1:0]  commit_rob_id;
  logic                  store_commit;
  logic [DEPTH_BIT-1:0]  store_rob_id;
  logic                  flush_out;
  logic [31:0]           flush_pc;

  modport master (
    output issue_valid, issue_type, issue_rd, issue_pred_taken, issue_alt_pc,
    input  issue_ready, issue_rob_id,
    output cdb_valid, cdb_rob_id, cdb_value, cdb_taken,
    output qa_id, qb_id,
    input  qa_ready, qb_ready, qa_value, qb_value,
    input  commit_valid, commit_rd, commit_value, commit_rob_id,
    input  store_commit, store_rob_id, flush_out, flush_pc
  );

  modport slave (
    input  issue_valid, issue_type, issue_rd, issue_pred_taken, issue_alt_pc,
    output issue_ready, issue_rob_id,
    input  cdb_valid, cdb_rob_id, cdb_value, cdb_taken,
    input  qa_id, qb_id,
    output qa_ready, qb_ready, qa_value, qb_value,
    output commit_valid, commit_rd, commit_value, commit_rob_id,
    output store_commit, store_rob_id, flush_out, flush_pc
  );

endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue: tag allocation, CDB capture, commit and flush.
// Define ROB_BYPASS_EN to let operand queries see a same-cycle CDB broadcast.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH_BIT = ROB_WIDTH_BIT
) (
  input logic             clk_in,
  input logic             rst_in,
  input logic             rdy_in,
  reorder_buffer_if.slave bus
);

  localparam int ENTRIES = 1 << DEPTH_BIT;

  typedef logic [DEPTH_BIT-1:0] ptr_t;
  typedef logic [DEPTH_BIT:0]   cnt_t;

  logic                  valid_q     [ENTRIES];
  logic                  valid_d     [ENTRIES];
  logic                  ready_q     [ENTRIES];
  logic                  ready_d     [ENTRIES];
  rob_type_e             type_q      [ENTRIES];
  rob_type_e             type_d      [ENTRIES];
  logic [REG_ID_BIT-1:0] rd_q        [ENTRIES];
  logic [REG_ID_BIT-1:0] rd_d        [ENTRIES];
  logic                  predTaken_q [ENTRIES];
  logic                  predTaken_d [ENTRIES];
  logic [31:0]           altPc_q     [ENTRIES];
  logic [31:0]           altPc_d     [ENTRIES];
  logic [31:0]           value_q     [ENTRIES];
  logic [31:0]           value_d     [ENTRIES];
  logic                  taken_q     [ENTRIES];
  logic                  taken_d     [ENTRIES];

  ptr_t head_q, head_d, tail_q, tail_d;
  cnt_t count_q, count_d;

  logic                  commitValid_q, commitValid_d;
  logic [REG_ID_BIT-1:0] commitRd_q, commitRd_d;
  logic [31:0]           commitValue_q, commitValue_d;
  ptr_t                  commitRobId_q, commitRobId_d;
  logic                  storeCommit_q, storeCommit_d;
  ptr_t                  storeRobId_q, storeRobId_d;
  logic                  flush_q, flush_d;
  logic [31:0]           flushPc_q, flushPc_d;

  logic       issueReady, issueFire, commitFire, mispredict;
  issue_dec_t issueDec;

  // Full-ness comes only from the registered count, so a full buffer
  // refuses issue even on an edge that also commits.
  assign issueReady = count_q < cnt_t'(ENTRIES);
  assign issueDec   = decode_issue(bus.issue_type, bus.issue_rd);
  assign commitFire = rdy_in && (count_q != '0) && valid_q[head_q] && ready_q[head_q];
  assign mispredict = commitFire && (type_q[head_q] == ROB_TYPE_BRANCH) &&
                      (taken_q[head_q] != predTaken_q[head_q]);
  assign issueFire  = rdy_in && bus.issue_valid && issueReady && !mispredict;

  always_comb begin
    valid_d       = valid_q;
    ready_d       = ready_q;
    type_d        = type_q;
    rd_d          = rd_q;
    predTaken_d   = predTaken_q;
    altPc_d       = altPc_q;
    value_d       = value_q;
    taken_d       = taken_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q + cnt_t'(issueFire) - cnt_t'(commitFire);
    commitValid_d = 1'b0;
    commitRd_d    = commitRd_q;
    commitValue_d = commitValue_q;
    commitRobId_d = commitRobId_q;
    storeCommit_d = 1'b0;
    storeRobId_d  = storeRobId_q;
    flush_d       = 1'b0;
    flushPc_d     = flushPc_q;

    // Capture only lands in live entries; commit sees it one edge later.
    if (rdy_in && bus.cdb_valid && valid_q[bus.cdb_rob_id]) begin
      ready_d[bus.cdb_rob_id] = 1'b1;
      value_d[bus.cdb_rob_id] = bus.cdb_value;
      taken_d[bus.cdb_rob_id] = bus.cdb_taken;
    end

    if (issueFire) begin
      valid_d[tail_q]     = 1'b1;
      ready_d[tail_q]     = 1'b0;
      type_d[tail_q]      = issueDec.kind;
      rd_d[tail_q]        = issueDec.rd;
      predTaken_d[tail_q] = bus.issue_pred_taken;
      altPc_d[tail_q]     = bus.issue_alt_pc;
      tail_d              = tail_q + ptr_t'(1);
    end

    if (commitFire) begin
      head_d          = head_q + ptr_t'(1);
      valid_d[head_q] = 1'b0;
      case (type_q[head_q])
        ROB_TYPE_STORE: begin
          storeCommit_d = 1'b1;
          storeRobId_d  = head_q;
        end
        ROB_TYPE_BRANCH: begin
          if (mispredict) begin
            flush_d   = 1'b1;
            flushPc_d = altPc_q[head_q];
            for (int i = 0; i < ENTRIES; i++) valid_d[i] = 1'b0;
            tail_d    = head_q + ptr_t'(1);
            count_d   = '0;
          end
        end
        default: begin
          commitValid_d = 1'b1;
          commitRd_d    = rd_q[head_q];
          commitValue_d = value_q[head_q];
          commitRobId_d = head_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]     <= 1'b0;
        ready_q[i]     <= 1'b0;
        type_q[i]      <= ROB_TYPE_REG;
        rd_q[i]        <= '0;
        predTaken_q[i] <= 1'b0;
        altPc_q[i]     <= '0;
        value_q[i]     <= '0;
        taken_q[i]     <= 1'b0;
      end
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      commitValid_q <= 1'b0;
      commitRd_q    <= '0;
      commitValue_q <= '0;
      commitRobId_q <= '0;
      storeCommit_q <= 1'b0;
      storeRobId_q  <= '0;
      flush_q       <= 1'b0;
      flushPc_q     <= '0;
    end else begin
      valid_q       <= valid_d;
      ready_q       <= ready_d;
      type_q        <= type_d;
      rd_q          <= rd_d;
      predTaken_q   <= predTaken_d;
      altPc_q       <= altPc_d;
      value_q       <= value_d;
      taken_q       <= taken_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      commitValid_q <= commitValid_d;
      commitRd_q    <= commitRd_d;
      commitValue_q <= commitValue_d;
      commitRobId_q <= commitRobId_d;
      storeCommit_q <= storeCommit_d;
      storeRobId_q  <= storeRobId_d;
      flush_q       <= flush_d;
      flushPc_q     <= flushPc_d;
    end
  end

  assign bus.issue_ready   = issueReady;
  assign bus.issue_rob_id  = tail_q;
  assign bus.commit_valid  = commitValid_q;
  assign bus.commit_rd     = commitRd_q;
  assign bus.commit_value  = commitValue_q;
  assign bus.commit_rob_id = commitRobId_q;
  assign bus.store_commit  = storeCommit_q;
  assign bus.store_rob_id  = storeRobId_q;
  assign bus.flush_out     = flush_q;
  assign bus.flush_pc      = flushPc_q;

  logic qaHit, qbHit;
  assign qaHit = valid_q[bus.qa_id] && ready_q[bus.qa_id];
  assign qbHit = valid_q[bus.qb_id] && ready_q[bus.qb_id];

`ifdef ROB_BYPASS_EN
  // A broadcast to a live entry is visible to dispatch in the same cycle.
  logic qaByp, qbByp;
  assign qaByp        = bus.cdb_valid && (bus.cdb_rob_id == bus.qa_id) && valid_q[bus.qa_id];
  assign qbByp        = bus.cdb_valid && (bus.cdb_rob_id == bus.qb_id) && valid_q[bus.qb_id];
  assign bus.qa_ready = qaByp || qaHit;
  assign bus.qb_ready = qbByp || qbHit;
  assign bus.qa_value = qaByp ? bus.cdb_value : (qaHit ? value_q[bus.qa_id] : '0);
  assign bus.qb_value = qbByp ? bus.cdb_value : (qbHit ? value_q[bus.qb_id] : '0);
`else
  assign bus.qa_ready = qaHit;
  assign bus.qb_ready = qbHit;
  assign bus.qa_value = qaHit ? value_q[bus.qa_id] : '0;
  assign bus.qb_value = qbHit ? value_q[bus.qb_id] : '0;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: expected retirements are queued at
// issue time and matched by a monitor whenever a commit/store/flush pulse appears.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  localparam int DB = 3;

  typedef enum int {K_REG, K_STORE, K_FLUSH} kind_e;
  typedef struct {
    kind_e       kind;
    logic [4:0]  rd;
    logic [31:0] value;
    logic [2:0]  tag;
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   total = 0;
  int   bad   = 0;
  exp_t expQ[$];
  exp_t monE;
  logic [2:0] monPulses;
  logic [2:0] monReq;

  always #5 clk = ~clk;

  reorder_buffer_if #(.DEPTH_BIT(DB)) bus ();

  reorder_buffer #(.DEPTH_BIT(DB)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .rdy_in(rdy),
    .bus   (bus)
  );

  // Every retirement pulse must match the oldest outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (rst === 1'b0 && (bus.commit_valid === 1'b1 || bus.store_commit === 1'b1 ||
                         bus.flush_out === 1'b1)) begin
      monPulses = {bus.flush_out, bus.store_commit, bus.commit_valid};
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_pulse: got flush/store/commit=%b, required none", monPulses);
      end else begin
        monE   = expQ.pop_front();
        monReq = (monE.kind == K_REG) ? 3'b001 : (monE.kind == K_STORE) ? 3'b010 : 3'b100;
        if (monPulses !== monReq) begin
          bad++;
          $display("[TB] FAIL pulse_kind: got %b, required %b", monPulses, monReq);
        end
        total++;
        case (monE.kind)
          K_REG:
            if ({bus.commit_rd, bus.commit_value, bus.commit_rob_id} !== {monE.rd, monE.value, monE.tag}) begin
              bad++;
              $display("[TB] FAIL commit_fields: got rd=%0d value=%h tag=%0d, required rd=%0d value=%h tag=%0d",
                       bus.commit_rd, bus.commit_value, bus.commit_rob_id, monE.rd, monE.value, monE.tag);
            end
          K_STORE:
            if (bus.store_rob_id !== monE.tag) begin
              bad++;
              $display("[TB] FAIL store_tag: got %0d, required %0d", bus.store_rob_id, monE.tag);
            end
          default:
            if (bus.flush_pc !== monE.pc) begin
              bad++;
              $display("[TB] FAIL flush_pc: got %h, required %h", bus.flush_pc, monE.pc);
            end
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    rdy                  = 1'b1;
    bus.issue_valid      = 1'b0;
    bus.issue_type       = 2'd0;
    bus.issue_rd         = '0;
    bus.issue_pred_taken = 1'b0;
    bus.issue_alt_pc     = '0;
    bus.cdb_valid        = 1'b0;
    bus.cdb_rob_id       = '0;
    bus.cdb_value        = '0;
    bus.cdb_taken        = 1'b0;
    bus.qa_id            = '0;
    bus.qb_id            = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) tick();
    rst = 1'b0;
    expQ.delete();
    tick();
  endtask

  function automatic void push_exp(kind_e k, logic [4:0] rd, logic [31:0] v,
                                   logic [2:0] tag, logic [31:0] pc);
    exp_t e;
    e.kind = k; e.rd = rd; e.value = v; e.tag = tag; e.pc = pc;
    expQ.push_back(e);
  endfunction

  task automatic issue(input logic [1:0] typ, input logic [4:0] rd, input logic pred,
                       input logic [31:0] alt, input logic [2:0] expTag);
    bus.issue_valid      = 1'b1;
    bus.issue_type       = typ;
    bus.issue_rd         = rd;
    bus.issue_pred_taken = pred;
    bus.issue_alt_pc     = alt;
    #1;
    total++;
    if (bus.issue_rob_id !== expTag) begin
      bad++;
      $display("[TB] FAIL issue_tag: got %0d, required %0d", bus.issue_rob_id, expTag);
    end
    tick();
    bus.issue_valid = 1'b0;
  endtask

  task automatic cdb(input logic [2:0] tag, input logic [31:0] v, input logic tk);
    bus.cdb_valid  = 1'b1;
    bus.cdb_rob_id = tag;
    bus.cdb_value  = v;
    bus.cdb_taken  = tk;
    tick();
    bus.cdb_valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound && expQ.size() != 0; i++) tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #3 rst = 1'b1;
    #1;
    total++;
    if ({bus.issue_ready, bus.issue_rob_id} !== {1'b1, 3'd0}) begin
      bad++;
      $display("[TB] FAIL reset_issue: got ready=%b tag=%0d, required ready=1 tag=0", bus.issue_ready, bus.issue_rob_id);
    end
    total++;
    if ({bus.commit_valid, bus.store_commit, bus.flush_out} !== 3'b000) begin
      bad++;
      $display("[TB] FAIL reset_pulses: got %b, required 000", {bus.commit_valid, bus.store_commit, bus.flush_out});
    end
    total++;
    if ({bus.qa_ready, bus.qa_value} !== 33'd0) begin
      bad++;
      $display("[TB] FAIL reset_query: got ready=%b value=%h, required 0/0", bus.qa_ready, bus.qa_value);
    end
    do_reset();
  endtask

  task automatic test_single_commit();
    do_reset();
    push_exp(K_REG, 5'd5, 32'hDEADBEEF, 3'd0, 32'd0);
    issue(2'd0, 5'd5, 1'b0, 32'd0, 3'd0);
    cdb(3'd0, 32'hDEADBEEF, 1'b0);
    total++;
    if (bus.commit_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL early_commit: got %b, required 0", bus.commit_valid);
    end
    tick();
    total++;
    if (bus.commit_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL commit_latency: got %b, required 1", bus.commit_valid);
    end
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL single_drain: got %0d pending, required 0", expQ.size());
    end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      push_exp(K_REG, 5'(i + 1), 32'(100 + i), 3'(i), 32'd0);
      issue(2'd0, 5'(i + 1), 1'b0, 32'd0, 3'(i));
    end
    total++;
    if (bus.issue_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL full_ready: got %b, required 0", bus.issue_ready);
    end
    cdb(3'd0, 32'd100, 1'b0);
    bus.issue_valid = 1'b1;
    bus.issue_type  = 2'd0;
    bus.issue_rd    = 5'd9;
    tick();
    bus.issue_valid = 1'b0;
    total++;
    if ({bus.issue_ready, bus.issue_rob_id} !== {1'b1, 3'd0}) begin
      bad++;
      $display("[TB] FAIL full_refuse: got ready=%b tag=%0d, required ready=1 tag=0", bus.issue_ready, bus.issue_rob_id);
    end
    push_exp(K_REG, 5'd20, 32'd200, 3'd0, 32'd0);
    issue(2'd0, 5'd20, 1'b0, 32'd0, 3'd0);
    for (int i = 1; i < 8; i++) cdb(3'(i), 32'(100 + i), 1'b0);
    cdb(3'd0, 32'd200, 1'b0);
    wait_drain(40);
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL wrap_drain: got %0d pending, required 0", expQ.size());
    end
  endtask

  task automatic test_out_of_order();
    do_reset();
    push_exp(K_REG, 5'd10, 32'hA, 3'd0, 32'd0);
    push_exp(K_REG, 5'd11, 32'hB, 3'd1, 32'd0);
    issue(2'd0, 5'd10, 1'b0, 32'd0, 3'd0);
    issue(2'd0, 5'd11, 1'b0, 32'd0, 3'd1);
    cdb(3'd1, 32'hB, 1'b0);
    cdb(3'd0, 32'hA, 1'b0);
    total++;
    if (bus.commit_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ooo_hold: got %b, required 0", bus.commit_valid);
    end
    tick();
    total++;
    if ({bus.commit_valid, bus.commit_rob_id} !== {1'b1, 3'd0}) begin
      bad++;
      $display("[TB] FAIL ooo_first: got valid=%b tag=%0d, required 1/0", bus.commit_valid, bus.commit_rob_id);
    end
    tick();
    total++;
    if ({bus.commit_valid, bus.commit_rob_id} !== {1'b1, 3'd1}) begin
      bad++;
      $display("[TB] FAIL ooo_second: got valid=%b tag=%0d, required 1/1", bus.commit_valid, bus.commit_rob_id);
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    issue(2'd2, 5'd0, 1'b0, 32'h1000, 3'd0);
    issue(2'd0, 5'd1, 1'b0, 32'd0, 3'd1);
    issue(2'd0, 5'd2, 1'b0, 32'd0, 3'd2);
    issue(2'd3, 5'd3, 1'b0, 32'd0, 3'd3);
    cdb(3'd1, 32'd11, 1'b0);
    cdb(3'd2, 32'd22, 1'b0);
    cdb(3'd3, 32'd33, 1'b0);
    push_exp(K_FLUSH, 5'd0, 32'd0, 3'd0, 32'h1000);
    cdb(3'd0, 32'd0, 1'b1);
    bus.issue_valid = 1'b1;
    bus.issue_type  = 2'd0;
    bus.issue_rd    = 5'd4;
    tick();
    bus.issue_valid = 1'b0;
    total++;
    if ({bus.flush_out, bus.flush_pc, bus.commit_valid} !== {1'b1, 32'h1000, 1'b0}) begin
      bad++;
      $display("[TB] FAIL flush: got flush=%b pc=%h commit=%b, required 1/00001000/0",
               bus.flush_out, bus.flush_pc, bus.commit_valid);
    end
    total++;
    if ({bus.issue_ready, bus.issue_rob_id} !== {1'b1, 3'd1}) begin
      bad++;
      $display("[TB] FAIL flush_tail: got ready=%b tag=%0d, required ready=1 tag=1", bus.issue_ready, bus.issue_rob_id);
    end
    bus.qa_id = 3'd2;
    #1;
    total++;
    if (bus.qa_ready !== 1'b0) begin
      bad++;
      $display("[TB] FAIL flush_cleared: got %b, required 0", bus.qa_ready);
    end
    repeat (4) tick();
    push_exp(K_REG, 5'd6, 32'd66, 3'd1, 32'd0);
    issue(2'd0, 5'd6, 1'b0, 32'd0, 3'd1);
    cdb(3'd1, 32'd66, 1'b0);
    wait_drain(10);
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL flush_drain: got %0d pending, required 0", expQ.size());
    end
  endtask

  task automatic test_store();
    do_reset();
    push_exp(K_REG, 5'd3, 32'h33, 3'd0, 32'd0);
    issue(2'd0, 5'd3, 1'b0, 32'd0, 3'd0);
    issue(2'd2, 5'd0, 1'b1, 32'h2000, 3'd1);
    push_exp(K_STORE, 5'd0, 32'd0, 3'd2, 32'd0);
    issue(2'd1, 5'd0, 1'b0, 32'd0, 3'd2);
    cdb(3'd0, 32'h33, 1'b0);
    cdb(3'd1, 32'd0, 1'b1);
    cdb(3'd2, 32'h44, 1'b0);
    for (int i = 0; i < 10 && bus.store_commit !== 1'b1; i++) tick();
    total++;
    if ({bus.store_commit, bus.store_rob_id, bus.commit_valid} !== {1'b1, 3'd2, 1'b0}) begin
      bad++;
      $display("[TB] FAIL store: got store=%b tag=%0d commit=%b, required 1/2/0",
               bus.store_commit, bus.store_rob_id, bus.commit_valid);
    end
    wait_drain(5);
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL store_drain: got %0d pending, required 0", expQ.size());
    end
  endtask

  task automatic test_query();
    logic        expRdy;
    logic [31:0] expVal;
    do_reset();
    for (int i = 0; i < 4; i++) issue(2'd0, 5'(i + 1), 1'b0, 32'd0, 3'(i));
    bus.qa_id      = 3'd3;
    bus.qb_id      = 3'd2;
    bus.cdb_valid  = 1'b1;
    bus.cdb_rob_id = 3'd3;
    bus.cdb_value  = 32'd7;
    bus.cdb_taken  = 1'b0;
`ifdef ROB_BYPASS_EN
    expRdy = 1'b1;
    expVal = 32'd7;
`else
    expRdy = 1'b0;
    expVal = 32'd0;
`endif
    #1;
    total++;
    if ({bus.qa_ready, bus.qa_value} !== {expRdy, expVal}) begin
      bad++;
      $display("[TB] FAIL query_same: got ready=%b value=%h, required ready=%b value=%h",
               bus.qa_ready, bus.qa_value, expRdy, expVal);
    end
    total++;
    if ({bus.qb_ready, bus.qb_value} !== 33'd0) begin
      bad++;
      $display("[TB] FAIL query_other: got ready=%b value=%h, required 0/0", bus.qb_ready, bus.qb_value);
    end
    tick();
    bus.cdb_valid = 1'b0;
    #1;
    total++;
    if ({bus.qa_ready, bus.qa_value} !== {1'b1, 32'd7}) begin
      bad++;
      $display("[TB] FAIL query_next: got ready=%b value=%h, required 1/00000007", bus.qa_ready, bus.qa_value);
    end
  endtask

  task automatic test_pause();
    do_reset();
    push_exp(K_REG, 5'd8, 32'h88, 3'd0, 32'd0);
    issue(2'd0, 5'd8, 1'b0, 32'd0, 3'd0);
    cdb(3'd0, 32'h88, 1'b0);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bus.commit_valid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL pause_commit: got %b, required 0", bus.commit_valid);
      end
    end
    rdy = 1'b1;
    tick();
    total++;
    if ({bus.commit_valid, bus.commit_rd} !== {1'b1, 5'd8}) begin
      bad++;
      $display("[TB] FAIL resume_commit: got valid=%b rd=%0d, required 1/8", bus.commit_valid, bus.commit_rd);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    issue(2'd0, 5'd9, 1'b0, 32'd0, 3'd0);
    cdb(3'd0, 32'h99, 1'b0);
    rst = 1'b1;
    #1;
    total++;
    if ({bus.commit_valid, bus.issue_ready, bus.issue_rob_id} !== {1'b0, 1'b1, 3'd0}) begin
      bad++;
      $display("[TB] FAIL midreset_state: got commit=%b ready=%b tag=%0d, required 0/1/0",
               bus.commit_valid, bus.issue_ready, bus.issue_rob_id);
    end
    repeat (2) tick();
    rst = 1'b0;
    tick();
    bus.qa_id = 3'd0;
    #1;
    total++;
    if ({bus.commit_valid, bus.qa_ready} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL midreset_after: got commit=%b qa_ready=%b, required 0/0", bus.commit_valid, bus.qa_ready);
    end
  endtask

  initial begin
    #200000;
    bad++;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1;
    test_reset();
    test_single_commit();
    test_full_wrap();
    test_out_of_order();
    test_mispredict();
    test_store();
    test_query();
    test_pause();
    test_mid_reset();
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
